// File: rtl/instr_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_queue
// Description : In-order instruction queue between fetch and decode. It takes
//               one {pc, instr} per cycle from fetch, presents the oldest entry
//               to decode through a valid/ready handshake, holds fetch off with
//               'stop' while full, and drops all contents on a redirect flush.
//
// Ports       : clk        - clock, rising-edge
//               reset      - asynchronous reset, active low
//               flush      - redirect; discard all entries
//               in_valid   - fetch presents an instruction
//               in_pc      - presented PC (64b)
//               in_instr   - presented instruction word (32b)
//               stop       - queue full, fetch must hold
//               out_valid  - head entry valid for decode
//               out_pc     - head entry PC
//               out_instr  - head entry instruction
//               out_ready  - decode consumes the head entry
//               count      - current occupancy, 0..DEPTH
//
// Build macro : INSTR_QUEUE_BYPASS_EN - when defined, an instruction arriving
//               at an empty queue is presented to decode in the same cycle and
//               is only written if decode does not take it.
//
// Revision    : 1.0 - initial release
// ============================================================================
module instr_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [63:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             stop,
    output logic             out_valid,
    output logic [63:0]      out_pc,
    output logic [31:0]      out_instr,
    input  logic             out_ready,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] c_depth_cnt = (PTR_W + 1)'(DEPTH);

    logic [63:0]      r_mem_pc    [DEPTH];
    logic [31:0]      r_mem_instr [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // Occupancy is tracked explicitly so that head==tail is never ambiguous.
    assign w_full  = (r_count == c_depth_cnt);
    assign w_empty = (r_count == '0);

    // stop depends on registered occupancy only; a pop in the same cycle does
    // not open a slot, which keeps out_ready off the path to fetch.
    assign stop  = w_full;
    assign count = r_count;

`ifdef INSTR_QUEUE_BYPASS_EN
    logic w_bypass;

    // Empty queue: forward the fetch entry straight to decode. If decode takes
    // it this cycle it is never written into storage.
    assign w_bypass  = w_empty & in_valid & ~flush;
    assign w_push    = in_valid & ~w_full & ~flush & ~(w_bypass & out_ready);
    assign w_pop     = ~w_empty & out_ready & ~flush;
    assign out_valid = ~w_empty | w_bypass;
    assign out_pc    = w_bypass ? in_pc    : r_mem_pc[r_head];
    assign out_instr = w_bypass ? in_instr : r_mem_instr[r_head];
`else
    assign w_push    = in_valid & ~w_full & ~flush;
    assign w_pop     = ~w_empty & out_ready & ~flush;
    assign out_valid = ~w_empty;
    assign out_pc    = r_mem_pc[r_head];
    assign out_instr = r_mem_instr[r_head];
`endif

    // Storage carries no reset; its contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_tail]    <= in_pc;
            r_mem_instr[r_tail] <= in_instr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_depth_pow2: assert property (@(posedge clk)
        ((DEPTH & (DEPTH - 1)) == 0) && (DEPTH >= 2));

    a_count_max: assert property (@(posedge clk) disable iff (!reset)
        r_count <= c_depth_cnt);

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset)
        !(w_pop && w_empty));
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_queue
// Description : Directed self-checking bench for instr_queue (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic [63:0]      in_pc;
    logic [31:0]      in_instr;
    logic             stop;
    logic             out_valid;
    logic [63:0]      out_pc;
    logic [31:0]      out_instr;
    logic             out_ready;
    logic [PTR_W:0]   count;

    int checks   = 0;
    int failures = 0;

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .stop      (stop),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Instruction word is derived from the PC so both fields can be checked.
    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return {16'h0013, pc[15:0]};
    endfunction

    task automatic drive(input logic v, input logic [63:0] pc, input logic rdy);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = instr_of(pc);
        out_ready = rdy;
    endtask

    // Advance one edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] exp_pc;

        reset = 1'b0;
        flush = 1'b0;
        drive(1'b0, 64'h0, 1'b0);

        // Reset held for 2 cycles
        step();
        step();
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_stop", 64'(stop), 64'd0);
        reset = 1'b1;

        // Fill to DEPTH with decode stalled
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h8000_0000 + 64'(4 * i), 1'b0);
            step();
            check("fill_count", 64'(count), 64'(i + 1));
        end
        check("fill_stop", 64'(stop), 64'd1);
        drive(1'b1, 64'h8000_0010, 1'b0);
        step();
        check("full_refuse_count", 64'(count), 64'd4);
        check("full_head_pc", out_pc, 64'h8000_0000);
        check("full_head_instr", 64'(out_instr), 64'(instr_of(64'h8000_0000)));

        // Drain in order
        drive(1'b0, 64'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            exp_pc = 64'h8000_0000 + 64'(4 * i);
            check("drain_valid", 64'(out_valid), 64'd1);
            check("drain_pc", out_pc, exp_pc);
            step();
        end
        check("drain_valid_end", 64'(out_valid), 64'd0);
        check("drain_count_end", 64'(count), 64'd0);
        check("drain_stop_end", 64'(stop), 64'd0);

        // Refill, then pop while full: input refused, no pop-through
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h8000_0020 + 64'(4 * i), 1'b0);
            step();
        end
        drive(1'b1, 64'h8000_0030, 1'b1);
        #1;
        check("fullpop_stop", 64'(stop), 64'd1);
        step();
        check("fullpop_count", 64'(count), 64'd3);
        check("fullpop_stop_after", 64'(stop), 64'd0);
        check("fullpop_head", out_pc, 64'h8000_0024);

        // Concurrent push/pop at 3 entries across pointer wrap
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 64'h8000_0030 + 64'(4 * k), 1'b1);
            #1;
            check("wrap_pc", out_pc, 64'h8000_0024 + 64'(4 * k));
            step();
            check("wrap_count", 64'(count), 64'd3);
        end
        check("wrap_head", out_pc, 64'h8000_004C);

        // Pop one to reach 2 entries, then flush with a same-cycle push
        drive(1'b0, 64'h0, 1'b1);
        step();
        check("preflush_count", 64'(count), 64'd2);
        flush = 1'b1;
        drive(1'b1, 64'h8000_0100, 1'b1);
        step();
        flush = 1'b0;
        drive(1'b0, 64'h0, 1'b0);
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        step();
        check("flush_valid_hold", 64'(out_valid), 64'd0);
        drive(1'b1, 64'h8000_0104, 1'b0);
        step();
        drive(1'b0, 64'h0, 1'b0);
        check("postflush_pc", out_pc, 64'h8000_0104);
        check("postflush_count", 64'(count), 64'd1);

        // Async reset between edges
        drive(1'b1, 64'h8000_0108, 1'b0);
        step();
        drive(1'b0, 64'h0, 1'b0);
        check("prereset_count", 64'(count), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        check("async_count", 64'(count), 64'd0);
        check("async_valid", 64'(out_valid), 64'd0);
        #1;
        reset = 1'b1;
        step();

`ifdef INSTR_QUEUE_BYPASS_EN
        // Empty queue: same-cycle forward, consumed without storage
        drive(1'b1, 64'h8000_0200, 1'b1);
        #1;
        check("bypass_valid", 64'(out_valid), 64'd1);
        check("bypass_pc", out_pc, 64'h8000_0200);
        step();
        drive(1'b0, 64'h0, 1'b0);
        check("bypass_count", 64'(count), 64'd0);
`else
        // Empty queue: one-cycle latency, nothing forwarded
        drive(1'b1, 64'h8000_0200, 1'b1);
        #1;
        check("lat_valid_same", 64'(out_valid), 64'd0);
        step();
        drive(1'b0, 64'h0, 1'b0);
        check("lat_count", 64'(count), 64'd1);
        check("lat_pc", out_pc, 64'h8000_0200);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
